async_result_sink: RTL

Clocked consumer placed directly downstream of the asynchronous square-root pipeline's final output stage. Takes the dual-rail `fp_components_t` result (exponent + fraction) under a four-phase return-to-zero handshake, synchronises it into the `clk` domain, and completes the handshake by driving the pipeline's acknowledge input. Packs each captured result into an IEEE-754 single-precision word and buffers it in a small FIFO with a valid/ready interface toward synchronous logic.

---
 rtl/async_result_sink_if.sv | 32 +++
 rtl/async_result_sink.sv | 120 ++++++++++++
 2 files changed

// File: rtl/async_result_sink_if.sv
// Result types for the async square-root pipeline, and the handshake/stream bundle of async_result_sink.
// Dual-rail code per bit is {t,f}: 10 = one, 01 = zero, 00 = NULL, 11 = illegal.
package pa_AsyncCordic;
  parameter int EW = 7;
  parameter int FW = 22;

  typedef logic [1:0] dr_t;

  typedef struct packed {
    dr_t [EW:0] exp;
    dr_t [FW:0] fraction;
  } fp_components_t;
endpackage

interface async_result_sink_if;
  pa_AsyncCordic::fp_components_t                               data_i;
  logic                                                         ack_i;
  logic [pa_AsyncCordic::EW + pa_AsyncCordic::FW + 2:0]        result_o;
  logic                                                         valid_o;
  logic                                                         ready_i;
  logic                                                         err_o;

  modport slave (
    input  data_i, ready_i,
    output ack_i, result_o, valid_o, err_o
  );

  modport master (
    output data_i, ready_i,
    input  ack_i, result_o, valid_o, err_o
  );
endinterface

// File: rtl/async_result_sink.sv
// Captures a dual-rail result into clk, acks it four-phase, packs it as a float and queues it.
// Ack/valid rise SYNC_STAGES+1 edges after data settles; a full FIFO withholds the ack.
module async_result_sink #(
  parameter int EW          = pa_AsyncCordic::EW,
  parameter int FW          = pa_AsyncCordic::FW,
  parameter int SYNC_STAGES = 2,
  parameter int DEPTH       = 2
) (
  input  logic                 clk,
  input  logic                 arst,
  async_result_sink_if.slave   bus
);

  localparam int NB = EW + FW + 2;
  localparam int NR = 2 * NB;
  localparam int WW = NB + 1;
  localparam int PW = $clog2(DEPTH);

  localparam logic [PW:0]   CNT_ONE  = (PW + 1)'(1);
  localparam logic [PW:0]   CNT_FULL = (PW + 1)'(DEPTH);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  typedef enum logic [1:0] {IDLE, WAIT_NULL, ERROR} state_e;

  state_e          state_q, state_d;
  logic [NR-1:0]   rails;
  logic [NR-1:0]   sync_q [SYNC_STAGES];
  logic [NR-1:0]   s;
  logic [NB-1:0]   t_vec, f_vec;
  logic            complete, is_null, illegal;

  logic [WW-1:0]   mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [PW:0]     cnt_q, cnt_d;
  logic            full, valid, pop, push, can_push;

  assign rails = bus.data_i;

  always_ff @(posedge clk) begin
    if (!arst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= rails;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  always_comb begin
    t_vec = '0;
    f_vec = '0;
    for (int i = 0; i < NB; i++) begin
      t_vec[i] = s[2*i+1];
      f_vec[i] = s[2*i];
    end
  end

  // Monotonic rails mean s cannot change once complete, so no extra qualification.
  assign complete = &(t_vec | f_vec);
  assign is_null  = ~|s;
  assign illegal  = |(t_vec & f_vec);

  assign full     = (cnt_q == CNT_FULL);
  assign valid    = (cnt_q != '0);
  assign pop      = valid && bus.ready_i;
  assign can_push = !full || pop;

  always_comb begin
    state_d = state_q;
    push    = 1'b0;
    case (state_q)
      IDLE: begin
        if (illegal) begin
          state_d = ERROR;
        end else if (complete && can_push) begin
          state_d = WAIT_NULL;
          push    = 1'b1;
        end
      end
      WAIT_NULL: begin
        if (illegal)      state_d = ERROR;
        else if (is_null) state_d = IDLE;
      end
      ERROR:   state_d = ERROR;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
    else if (!push && pop) cnt_d = cnt_q - CNT_ONE;
  end

  // When full, a same-edge push lands in the slot being popped.
  always_ff @(posedge clk) begin
    if (!arst) begin
      state_q  <= IDLE;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (push) begin
        mem_q[wr_ptr_q] <= {1'b0, t_vec};
        wr_ptr_q        <= wr_ptr_q + PTR_ONE;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  assign bus.ack_i    = (state_q == WAIT_NULL);
  assign bus.err_o    = (state_q == ERROR);
  assign bus.valid_o  = valid;
  assign bus.result_o = mem_q[rd_ptr_q];

endmodule
